// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, issue and status signals of the multi-port
// register file. The core (or a bench) drives through the master modport.
// The register file itself connects through the slave modport.
interface regfile_mp_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] ra;
   logic [NUM_RD*XLEN-1:0]   rd;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     we0;
   logic [ADDR_W-1:0]        wa0;
   logic [XLEN-1:0]          wd0;
   logic                     we1;
   logic [ADDR_W-1:0]        wa1;
   logic [XLEN-1:0]          wd1;
   logic                     iss_valid;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     wr_collide;
   logic                     any_busy;

   modport master (
      output ra, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_addr,
      input  rd, rd_busy, wr_collide, any_busy
   );

   modport slave (
      input  ra, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_addr,
      output rd, rd_busy, wr_collide, any_busy
   );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: integer register file for the pipelined core. It has NUM_RD
// combinational read ports and two write ports. Port 0 carries ALU writeback.
// Port 1 carries load writeback and wins when both ports target the same
// register. A per-register pending scoreboard lets the hazard unit stall on
// in-flight destinations. Register 0 can be hardwired to zero, and same-cycle
// writes can be forwarded to the read ports.
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic        clk,
   input  logic        rst,
   regfile_mp_if.slave bus
);
   localparam bit ZR = (ZERO_REG != 0);
   localparam bit BP = (BYPASS != 0);

   logic [XLEN-1:0]        regs [DEPTH];
   logic [DEPTH-1:0]       pending;
   logic [DEPTH-1:0]       pending_nxt;
   logic                   collide_q;
   logic                   collide_nxt;
   logic                   wr0_ok;
   logic                   wr1_ok;
   logic [NUM_RD*XLEN-1:0] rd_vec;
   logic [NUM_RD-1:0]      busy_vec;

   // Writes to the hardwired zero register are dropped entirely
   assign wr0_ok = bus.we0 && !(ZR && (bus.wa0 == '0));
   assign wr1_ok = bus.we1 && !(ZR && (bus.wa1 == '0));

   assign collide_nxt = wr0_ok && wr1_ok && (bus.wa0 == bus.wa1);

   // Architectural state; port 1 is written last so it overrides port 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
         end
      end else begin
         if (wr0_ok) begin
            regs[bus.wa0] <= bus.wd0;
         end
         if (wr1_ok) begin
            regs[bus.wa1] <= bus.wd1;
         end
      end
   end

   // Scoreboard update: writebacks clear, issue sets afterwards so a newer producer wins
   always_comb begin
      pending_nxt = pending;
      if (bus.we0) begin
         pending_nxt[bus.wa0] = 1'b0;
      end
      if (bus.we1) begin
         pending_nxt[bus.wa1] = 1'b0;
      end
      if (bus.iss_valid) begin
         pending_nxt[bus.iss_addr] = 1'b1;
      end
      if (ZR) begin
         pending_nxt[0] = 1'b0;
      end
   end

   // Pending bits and the one-cycle write-collision flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending   <= '0;
         collide_q <= 1'b0;
      end else begin
         pending   <= pending_nxt;
         collide_q <= collide_nxt;
      end
   end

   // Read ports: zero-register rule first, then forwarded writes, then stored state.
   // A forwarded write also hides the pending bit, because the value is already here.
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              is_zero;
      logic              hit0;
      logic              hit1;

      assign a       = bus.ra[i*ADDR_W +: ADDR_W];
      assign is_zero = ZR && (a == '0);
      assign hit1    = BP && bus.we1 && (bus.wa1 == a);
      assign hit0    = BP && bus.we0 && (bus.wa0 == a);

      assign rd_vec[i*XLEN +: XLEN] = (!rst || is_zero) ? '0 :
                                      hit1              ? bus.wd1 :
                                      hit0              ? bus.wd0 :
                                                          regs[a];
      assign busy_vec[i] = rst && !hit0 && !hit1 && pending[a];
   end

   assign bus.rd         = rd_vec;
   assign bus.rd_busy    = busy_vec;
   assign bus.any_busy   = rst && (|pending);
   assign bus.wr_collide = collide_q;
endmodule
